// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped L1 cache.
package cache_types;

    // Line geometry: 32-byte lines holding eight 32-bit words.
    localparam int unsigned S_OFFSET       = 5;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned LINE_BITS      = 256;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    // Extract one 32-bit word from a line.
    function automatic logic [31:0] word_select(input line_t line, input logic [2:0] word);
        return line[32*word +: 32];
    endfunction

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Byte-merge a store into the selected word of a full line.
    function automatic line_t line_store(input line_t       line,
                                         input logic [2:0]  word,
                                         input logic [31:0] data,
                                         input logic [3:0]  be);
        line_t updated;
        updated = line;
        updated[32*word +: 32] = byte_merge(word_select(line, word), data, be);
        return updated;
    endfunction

endpackage

// File: rtl/dm_cache_line_array.sv
// Per-set valid/dirty/tag/data storage with combinational read,
// a full-line fill port and a byte-enabled word store port.
module dm_cache_line_array
    import cache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int S_TAG   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] i_index,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [S_TAG-1:0]   o_tag,
    output logic [255:0]       o_line,
    input  logic               i_fill_we,
    input  logic [S_TAG-1:0]   i_fill_tag,
    input  logic [255:0]       i_fill_line,
    input  logic               i_store_we,
    input  logic [2:0]         i_store_word,
    input  logic [31:0]        i_store_data,
    input  logic [3:0]         i_store_be,
    input  logic               i_clean
);

    localparam int SETS = 2**S_INDEX;

    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [S_TAG-1:0] r_tag  [SETS];
    line_t            r_data [SETS];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

    // Status bits: cleared by reset, updated by fill, store and writeback completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_store_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clean) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    // Tag and data payload; contents after reset are don't-care so no reset here.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_line;
        end else if (i_store_we) begin
            r_data[i_index] <= line_store(r_data[i_index], i_store_word, i_store_data, i_store_be);
        end
    end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with zero-wait hits
// and a single-line physical memory interface for fills and writebacks.
module dm_cache #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    import cache_types::*;

    if (S_OFFSET != 5) begin : g_bad_offset
        $error("dm_cache: S_OFFSET must be 5 (32-byte line)");
    end

    cache_state_t       r_state;
    cache_state_t       w_next;

    logic [S_TAG-1:0]   w_tag;
    logic [S_INDEX-1:0] w_index;
    logic [2:0]         w_word;
    logic               w_req;
    logic               w_hit;

    logic               w_valid;
    logic               w_dirty;
    logic [S_TAG-1:0]   w_stored_tag;
    logic [255:0]       w_line;

    logic               w_fill_we;
    logic               w_store_we;
    logic               w_clean;
    logic               w_unused;

    assign w_tag    = mem_address[31 -: S_TAG];
    assign w_index  = mem_address[S_OFFSET +: S_INDEX];
    assign w_word   = mem_address[4:2];
    assign w_req    = mem_read | mem_write;
    assign w_hit    = w_valid && (w_stored_tag == w_tag);
    assign w_unused = ^mem_address[1:0];

    dm_cache_line_array #(
        .S_INDEX (S_INDEX),
        .S_TAG   (S_TAG)
    ) u_lines (
        .clk          (clk),
        .rst          (rst),
        .i_index      (w_index),
        .o_valid      (w_valid),
        .o_dirty      (w_dirty),
        .o_tag        (w_stored_tag),
        .o_line       (w_line),
        .i_fill_we    (w_fill_we),
        .i_fill_tag   (w_tag),
        .i_fill_line  (pmem_rdata),
        .i_store_we   (w_store_we),
        .i_store_word (w_word),
        .i_store_data (mem_wdata),
        .i_store_be   (mem_byte_enable),
        .i_clean      (w_clean)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CHECK;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, hit handling and memory-side outputs; everything is held at 0
    // while rst is high so a reset mid-miss drops pmem_* and touches no storage.
    always_comb begin
        w_next       = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_fill_we    = 1'b0;
        w_store_we   = 1'b0;
        w_clean      = 1'b0;
        if (!rst) begin
            case (r_state)
                CHECK: begin
                    if (w_req) begin
                        if (w_hit) begin
                            mem_resp = 1'b1;
                            if (mem_write) begin
                                w_store_we = 1'b1;
                            end else begin
                                mem_rdata = word_select(w_line, w_word);
                            end
                        end else if (w_valid && w_dirty) begin
                            w_next = WRITEBACK;
                        end else begin
                            w_next = FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {w_stored_tag, w_index, {S_OFFSET{1'b0}}};
                    pmem_wdata   = w_line;
                    if (pmem_resp) begin
                        w_clean = 1'b1;
                        w_next  = FILL;
                    end
                end
                FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
                    if (pmem_resp) begin
                        w_fill_we = 1'b1;
                        w_next    = CHECK;
                    end
                end
                default: begin
                    w_next = CHECK;
                end
            endcase
        end
    end

endmodule
